histogram_loader: RTL and testbench

//   Reads a saved histogram back from the SD card into histogram RAM; counterpart to histogram_saver.

---
 rtl/hist_sd_pkg.sv | 22 ++
 rtl/histogram_loader_sd_byte_packer.sv | 44 ++++
 rtl/histogram_loader.sv | 194 +++++++++++++++++++
 tb/tb_histogram_loader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hist_sd_pkg.sv
// Shared SD-card histogram constants, state encoding and sector address helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package hist_sd_pkg;

    localparam int SD_SECTOR_BYTES = 512;
    localparam int BYTES_PER_BIN   = 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        REQ,
        RECV,
        FINISH
    } hist_load_state_t;

    // Byte address of an absolute sector index; 32-bit wrap, no overflow check.
    function automatic logic [31:0] sector_byte_addr(input logic [31:0] sector_idx);
        return sector_idx * 32'(SD_SECTOR_BYTES);
    endfunction

endpackage

// File: rtl/histogram_loader_sd_byte_packer.sv
// Pairs the SD read byte stream into bins: rising edge of byte_avail takes one byte, odd byte completes a word.
// Latency: word_vld/word_dat combinational in the cycle the odd byte's rising edge is seen.
// Backpressure: none; every rising edge while take_en is high is consumed, a held level counts once.
module sd_byte_packer
    import hist_sd_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         take_en,
    input  logic                         odd_byte,
    input  logic [7:0]                   byte_dat,
    input  logic                         byte_avail,
    output logic                         byte_take,
    output logic                         word_vld,
    output logic [8*BYTES_PER_BIN-1:0]   word_dat
);

    logic       avail_prev_q, avail_prev_d;
    logic [7:0] hi_q, hi_d;

    // Edge detect on the byte strobe and capture the high byte of each pair.
    always_comb begin
        avail_prev_d = byte_avail;
        hi_d         = hi_q;
        byte_take    = take_en & byte_avail & ~avail_prev_q;
        word_vld     = byte_take & odd_byte;
        word_dat     = {hi_q, byte_dat};
        if (byte_take && !odd_byte) begin
            hi_d = byte_dat;
        end
    end

    // Previous strobe level and high-byte holding register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avail_prev_q <= 1'b0;
            hi_q         <= 8'h00;
        end else begin
            avail_prev_q <= avail_prev_d;
            hi_q         <= hi_d;
        end
    end

endmodule

// File: rtl/histogram_loader.sv
// Loads a saved histogram slot from the SD card into histogram RAM (bins stored high byte first); optional HIST_LOAD_SUM_EN adds a running bin sum port.
// Latency: one cycle from a completing byte edge to we; done pulses the cycle after FINISH, after the last write.
// Backpressure: waits for sd_ready before each sector request; the controller owns the block until 512 bytes arrive.
module histogram_loader
    import hist_sd_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 16,
    parameter int SLOT_W      = 4,
    parameter int BASE_SECTOR = 0,
    parameter int SECTORS     = (2**ADDR_W) * BYTES_PER_BIN / SD_SECTOR_BYTES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SLOT_W-1:0] slot,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              we,
    input  logic              sd_ready,
    output logic [31:0]       sd_address,
    output logic              sd_rd,
    input  logic [7:0]        sd_dout,
    input  logic              sd_byte_available,
    output logic              loading,
    output logic              done
`ifdef HIST_LOAD_SUM_EN
    ,
    output logic [15:0]       sum
`endif
);

    localparam int SEC_W          = (SECTORS > 1) ? $clog2(SECTORS) : 1;
    localparam int BINS_PER_SECT  = SD_SECTOR_BYTES / BYTES_PER_BIN;

    hist_load_state_t    state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [SEC_W-1:0]    sector_q, sector_d;
    logic [8:0]          byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [31:0]         sd_address_q, sd_address_d;
    logic                sd_rd_q, sd_rd_d;
    logic                loading_q, loading_d;
    logic                done_q, done_d;

    logic                byte_take;
    logic                word_vld;
    logic [15:0]         word_dat;

    sd_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .take_en    (state_q == RECV),
        .odd_byte   (byte_cnt_q[0]),
        .byte_dat   (sd_dout),
        .byte_avail (sd_byte_available),
        .byte_take  (byte_take),
        .word_vld   (word_vld),
        .word_dat   (word_dat)
    );

    // Next-state and registered-output logic for the sector read sequence.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        sector_d     = sector_q;
        byte_cnt_d   = byte_cnt_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        we_d         = 1'b0;
        sd_address_d = sd_address_q;
        sd_rd_d      = 1'b0;
        loading_d    = loading_q;
        done_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    slot_d     = slot;
                    sector_d   = '0;
                    byte_cnt_d = '0;
                    loading_d  = 1'b1;
                    state_d    = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                sd_address_d = sector_byte_addr(32'(BASE_SECTOR)
                                                + 32'(slot_q) * 32'(SECTORS)
                                                + 32'(sector_q));
                if (sd_ready) begin
                    sd_rd_d = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                // Controller drops ready once it has taken the request.
                if (sd_ready) begin
                    sd_rd_d = 1'b1;
                end else begin
                    state_d = RECV;
                end
            end
            RECV: begin
                if (word_vld) begin
                    we_d    = 1'b1;
                    wdata_d = DATA_W'(word_dat);
                    waddr_d = ADDR_W'(32'(sector_q) * 32'(BINS_PER_SECT)
                                      + 32'(byte_cnt_q[8:1]));
                end
                if (byte_take) begin
                    byte_cnt_d = byte_cnt_q + 9'd1;
                    if (byte_cnt_q == 9'd511) begin
                        if (sector_q == SEC_W'(SECTORS - 1)) begin
                            state_d = FINISH;
                        end else begin
                            sector_d = sector_q + SEC_W'(1);
                            state_d  = WAIT_RDY;
                        end
                    end
                end
            end
            FINISH: begin
                done_d    = 1'b1;
                loading_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset clears outputs immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            sector_q     <= '0;
            byte_cnt_q   <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            sd_address_q <= '0;
            sd_rd_q      <= 1'b0;
            loading_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            sector_q     <= sector_d;
            byte_cnt_q   <= byte_cnt_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            sd_address_q <= sd_address_d;
            sd_rd_q      <= sd_rd_d;
            loading_q    <= loading_d;
            done_q       <= done_d;
        end
    end

    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign we         = we_q;
    assign sd_address = sd_address_q;
    assign sd_rd      = sd_rd_q;
    assign loading    = loading_q;
    assign done       = done_q;

`ifdef HIST_LOAD_SUM_EN
    logic [15:0] sum_q, sum_d;

    // Running modulo-2^16 sum of loaded bins, cleared when a load is accepted.
    always_comb begin
        sum_d = sum_q;
        if (state_q == IDLE && start) begin
            sum_d = 16'h0000;
        end else if (word_vld) begin
            sum_d = sum_q + word_dat;
        end
    end

    // Sum register, held after done until the next accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= 16'h0000;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;
`endif

endmodule

// File: tb/tb_histogram_loader.sv
`timescale 1ns/1ps
module tb_histogram_loader;

    localparam int ADDR_W = 10;
    localparam int SLOT_W = 4;
    localparam int BASE   = 0;
    localparam int SECT   = 4;
    localparam int NBINS  = 1024;
    localparam int NBYTES = 2048;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [SLOT_W-1:0] slot_i = '0;
    logic [ADDR_W-1:0] waddr;
    logic [15:0]       wdata;
    logic              we;
    logic              sd_ready;
    logic [31:0]       sd_address;
    logic              sd_rd;
    logic [7:0]        sd_dout;
    logic              sd_byte_available;
    logic              loading;
    logic              done;
`ifdef HIST_LOAD_SUM_EN
    logic [15:0]       sum;
`endif

    histogram_loader #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (16),
        .SLOT_W      (SLOT_W),
        .BASE_SECTOR (BASE),
        .SECTORS     (SECT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .slot              (slot_i),
        .waddr             (waddr),
        .wdata             (wdata),
        .we                (we),
        .sd_ready          (sd_ready),
        .sd_address        (sd_address),
        .sd_rd             (sd_rd),
        .sd_dout           (sd_dout),
        .sd_byte_available (sd_byte_available),
        .loading           (loading),
        .done              (done)
`ifdef HIST_LOAD_SUM_EN
        ,
        .sum               (sum)
`endif
    );

    always #20 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Slot image served by the SD model, and the expectations derived from it.
    logic [7:0]  img [NBYTES];
    logic [25:0] exp_bin[$];
    logic [31:0] exp_addr[$];
    logic [15:0] exp_sum = 16'h0000;
    int          cur_slot = 0;
    int          rd_cnt = 0;
    int          we_cnt = 0;
    int          done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_we"}, {31'd0, we}, 32'd0);
        chk({tag, "_sd_rd"}, {31'd0, sd_rd}, 32'd0);
        chk({tag, "_loading"}, {31'd0, loading}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_waddr"}, 32'(waddr), 32'd0);
        chk({tag, "_wdata"}, 32'(wdata), 32'd0);
        chk({tag, "_sd_address"}, sd_address, 32'd0);
    endtask

    // Behavioural SD controller read port: ready/rd handshake, 4-cycle byte strobes.
    initial begin
        sd_ready = 1'b1;
        sd_byte_available = 1'b0;
        sd_dout = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset && sd_rd && sd_ready) begin
                int sidx;
                bit abort;
                bit rd_seen;
                bit early;
                abort = 1'b0;
                rd_seen = 1'b0;
                early = 1'($urandom_range(0, 1));
                sidx = int'(sd_address >> 9) - BASE - cur_slot * SECT;
                if (sidx < 0 || sidx >= SECT) sidx = 0;
                sd_ready = 1'b0;
                sd_byte_available = 1'b0;
                repeat (2) @(negedge clk);
                for (int i = 0; i < 512 && !abort; i++) begin
                    sd_dout = img[sidx * 512 + i];
                    sd_byte_available = 1'b1;
                    for (int c = 0; c < 4 && !abort; c++) begin
                        @(negedge clk);
                        if (reset) abort = 1'b1;
                        if (sd_rd && i < 511) rd_seen = 1'b1;
                    end
                    sd_byte_available = 1'b0;
                    if (!abort) begin
                        repeat ($urandom_range(1, 2)) @(negedge clk);
                        if (reset) abort = 1'b1;
                    end
                    // Some sectors raise ready before the block ends.
                    if (early && i == 300) sd_ready = 1'b1;
                end
                sd_byte_available = 1'b0;
                sd_ready = 1'b1;
                if (!abort) chk("no_rd_in_recv", {31'd0, rd_seen}, 32'd0);
            end else begin
                // Stray strobes while no block is streaming must be ignored.
                sd_byte_available = ($urandom_range(0, 3) == 0);
                sd_dout = 8'($urandom);
            end
        end
    end

    // Monitor: pops expectations whenever the DUT writes, requests or finishes.
    initial begin
        logic rd_prev;
        logic done_prev;
        logic [25:0] e;
        logic [31:0] a;
        rd_prev = 1'b0;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rd_prev = 1'b0;
                done_prev = 1'b0;
            end else begin
                if (we) begin
                    we_cnt++;
                    if (exp_bin.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL bin_extra actual=waddr 0x%0h wdata 0x%0h required=no write", waddr, wdata);
                    end else begin
                        e = exp_bin.pop_front();
                        chk("bin", {6'd0, waddr, wdata}, {6'd0, e});
                    end
                end
                if (sd_rd && !rd_prev) begin
                    rd_cnt++;
                    if (exp_addr.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rd_extra actual=address 0x%0h required=no request", sd_address);
                    end else begin
                        a = exp_addr.pop_front();
                        chk("sd_address", sd_address, a);
                    end
                end
                if (done) begin
                    done_cnt++;
                    chk("done_pulse", {31'd0, done_prev}, 32'd0);
                    chk("we_count", 32'(we_cnt), 32'(NBINS));
                    chk("bins_left", 32'(exp_bin.size()), 32'd0);
                    chk("addr_left", 32'(exp_addr.size()), 32'd0);
                    chk("loading_at_done", {31'd0, loading}, 32'd0);
`ifdef HIST_LOAD_SUM_EN
                    chk("sum", 32'(sum), 32'(exp_sum));
`endif
                end
                rd_prev = sd_rd;
                done_prev = done;
            end
        end
    end

    // One slot load: mode 0 = byte index pattern, 1 = all 0xFF, 2 = random.
    task automatic do_load(input int s, input int mode, input bit mid_start, input bit do_reset);
        int base;
        logic [15:0] bin;
        for (int n = 0; n < NBYTES; n++) begin
            case (mode)
                0:       img[n] = 8'(n);
                1:       img[n] = 8'hFF;
                default: img[n] = 8'($urandom);
            endcase
        end
        exp_bin.delete();
        exp_addr.delete();
        exp_sum = 16'h0000;
        for (int k = 0; k < NBINS; k++) begin
            bin = {img[2 * k], img[2 * k + 1]};
            exp_bin.push_back({10'(k), bin});
            exp_sum = exp_sum + bin;
        end
        for (int sec = 0; sec < SECT; sec++) begin
            exp_addr.push_back(32'((BASE + s * SECT + sec) * 512));
        end
        cur_slot = s;
        rd_cnt = 0;
        we_cnt = 0;
        base = done_cnt;

        @(posedge clk); #1;
        start = 1'b1;
        slot_i = SLOT_W'(s);
        @(posedge clk); #1;
        start = 1'b0;
        slot_i = SLOT_W'($urandom);
        chk("loading_after_start", {31'd0, loading}, 32'd1);

        if (mid_start) begin
            for (int c = 0; c < 30000 && rd_cnt < 2; c++) @(posedge clk);
            chk("mid_start_reached", {31'd0, rd_cnt >= 2}, 32'd1);
            #1;
            start = 1'b1;
            slot_i = SLOT_W'(s + 1);
            @(posedge clk); #1;
            start = 1'b0;
            chk("loading_after_restart", {31'd0, loading}, 32'd1);
        end

        if (do_reset) begin
            for (int c = 0; c < 30000 && rd_cnt < 3; c++) @(posedge clk);
            chk("sector2_reached", {31'd0, rd_cnt >= 3}, 32'd1);
            repeat (100) @(posedge clk);
            #1;
            reset = 1'b1;
            exp_bin.delete();
            exp_addr.delete();
            #1;
            chk_reset_outputs("midreset");
            repeat (3) @(posedge clk);
            #1;
            reset = 1'b0;
            repeat (3) @(posedge clk);
            return;
        end

        for (int c = 0; c < 30000 && done_cnt == base; c++) @(posedge clk);
        chk("done_seen", 32'(done_cnt - base), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("idle_loading", {31'd0, loading}, 32'd0);
    endtask

    initial begin
        #5;
        chk_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);

        do_load(0, 0, 1'b0, 1'b0);
        do_load(3, 2, 1'b1, 1'b0);
        do_load(5, 1, 1'b0, 1'b0);
        do_load(2, 2, 1'b0, 1'b1);
        do_load(1, 2, 1'b0, 1'b0);
        do_load(int'($urandom_range(6, 15)), 2, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
